regfile_stack_ctrl: RTL and testbench
=====================================

REGFILE_STACK_CTRL -- requirements
Module: regfile_stack_ctrl

Interface
REQ-001 Depth, 4, stacked regfile depth parameter; saved-context capacity CAP = Depth-1; legal Depth >= 2.
REQ-002 i_clk  input  1  dedicated clock; all state updates on rising edge.
REQ-003 i_reset  input  1  dedicated reset, asynchronous, active-low.
REQ-004 i_enter_req  input  1  interrupt-entry request (context push), level, held until acked.
REQ-005 i_exit_req  input  1  interrupt-exit request (context pop), level, held until acked.
REQ-006 i_stall  input  1  pipeline hold; blocks acceptance of new requests.
REQ-007 i_err_clr  input  1  clears sticky error flags.
REQ-008 o_command  output  2  regfile command: 0 = none, 1 = push, 2 = pop; 3 never driven.
REQ-009 o_enter_ack  output  1  one-cycle pulse: entry request consumed.
REQ-010 o_exit_ack  output  1  one-cycle pulse: exit request consumed.
REQ-011 o_w_block  output  1  high = core must suppress regfile write enable.
REQ-012 o_depth  output  $clog2(Depth)  saved-context count, 0..CAP.
REQ-013 o_full / o_empty  output  1 each  o_depth == CAP / o_depth == 0.
REQ-014 o_overflow / o_underflow  output  1 each  sticky error flags.

Function
REQ-015 FSM states: IDLE, ISSUE, SETTLE. All outputs are registered or decoded from state only, with no combinational path from inputs.
REQ-016 IDLE: a request is accepted on an edge where i_stall = 0 and at least one request is high. If both requests are high, entry wins and exit stays pending.
REQ-017 Accepted entry with o_depth < CAP: next state ISSUE with o_command = push and o_enter_ack = 1 for exactly that ISSUE cycle.
REQ-018 Accepted exit with o_depth > 0: next state ISSUE with o_command = pop and o_exit_ack = 1 for exactly that ISSUE cycle.
REQ-019 Entry with o_depth == CAP: no push, stay IDLE, set o_overflow, no ack. The request stays pending and retries each cycle.
REQ-020 Exit with o_depth == 0: o_command stays none, stay IDLE, set o_underflow, pulse o_exit_ack next cycle so the request is consumed.
REQ-021 ISSUE lasts exactly one cycle and then goes to SETTLE. i_stall is ignored once in ISSUE.
REQ-022 o_depth increments (push) or decrements (pop) on the edge leaving ISSUE, so the new value is visible in SETTLE.
REQ-023 SETTLE lasts exactly one cycle with o_command = none, then returns to IDLE. No request is accepted in SETTLE.
REQ-024 o_w_block = 1 in ISSUE and SETTLE, 0 in IDLE.
REQ-025 Minimum spacing between consecutive commands is 3 cycles. Latency from request-high-in-IDLE to command is 1 cycle.
REQ-026 Requests dropped before acceptance are ignored without error. A request dropped during ISSUE or SETTLE has no effect, because the command has already been issued.
REQ-027 Sticky flags clear on the edge where i_err_clr = 1. If a set and a clear happen on the same edge, the set wins.
REQ-028 o_depth never wraps: it saturates at 0 and CAP by construction of REQ-019 and REQ-020.

Reset
REQ-029 i_reset low asynchronously forces: state IDLE, o_command = 0, both acks = 0, o_w_block = 0, o_depth = 0, o_empty = 1, o_full = 0 (Depth >= 2), both error flags = 0.
REQ-030 Reset asserted in ISSUE or SETTLE aborts the operation. The depth update is discarded and no ack or command is seen after reset.
REQ-031 After i_reset goes high, the first request can be accepted on the first rising edge.

Verification
REQ-032 Push then pop: entry at t0 gives push at t1 with ack, depth 1 at t2, IDLE at t3. Exit at t3 gives pop at t4, depth 0 at t5, o_empty = 1.
REQ-033 Fill and overflow (Depth = 4): three entries give depth 3 and o_full = 1. A fourth entry gives o_command = 0, o_overflow = 1, no ack. One exit then lets the pending entry push, and depth returns to 3.
REQ-034 Underflow: exit at depth 0 gives o_command = 0, o_exit_ack pulse, o_underflow = 1. i_err_clr = 1 then clears it.
REQ-035 Simultaneous entry and exit in IDLE at depth 1: push first (depth 2), then pop 3 cycles later (depth 1). o_w_block is high during both ISSUE/SETTLE windows.
REQ-036 Stall: request held with i_stall = 1 for 5 cycles gives no command. Command appears 1 cycle after i_stall falls.
REQ-037 Reset in ISSUE of a push at depth 2: async gives depth 0, command 0, no ack. A random push/pop/stall sequence then never shows o_command = 3, never leaves depth outside 0..CAP, and acks match depth changes.

Source files
------------

// File: rtl/regfile_stack_ctrl_if.sv
// regfile_stack_ctrl_if
// Request/ack and status bundle between a core and the stacked-regfile
// context controller.
//   master : core side, drives the entry/exit requests, stall and error clear
//   slave  : controller side, drives command, acks, write block, depth, flags
// Depth must match the Depth parameter of the attached controller.
interface regfile_stack_ctrl_if #(
    parameter int Depth = 4
) ();
    localparam int DW = $clog2(Depth);

    logic          i_enter_req;
    logic          i_exit_req;
    logic          i_stall;
    logic          i_err_clr;
    logic [1:0]    o_command;
    logic          o_enter_ack;
    logic          o_exit_ack;
    logic          o_w_block;
    logic [DW-1:0] o_depth;
    logic          o_full;
    logic          o_empty;
    logic          o_overflow;
    logic          o_underflow;

    modport master (
        output i_enter_req, i_exit_req, i_stall, i_err_clr,
        input  o_command, o_enter_ack, o_exit_ack, o_w_block,
               o_depth, o_full, o_empty, o_overflow, o_underflow
    );

    modport slave (
        input  i_enter_req, i_exit_req, i_stall, i_err_clr,
        output o_command, o_enter_ack, o_exit_ack, o_w_block,
               o_depth, o_full, o_empty, o_overflow, o_underflow
    );
endinterface

// File: rtl/regfile_stack_ctrl.sv
// regfile_stack_ctrl
// Sequences push/pop commands to a stacked register file on interrupt
// entry/exit. Each command occupies IDLE -> ISSUE -> SETTLE, during which the
// core's regfile write enable is blocked. Tracks the saved-context count
// (0..Depth-1) and raises sticky overflow/underflow flags.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : asynchronous active-low reset
//   bus     : slave side of regfile_stack_ctrl_if (requests, stall, err clear
//             in; command, acks, write block, depth, full/empty, flags out)
module regfile_stack_ctrl #(
    parameter int Depth = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    regfile_stack_ctrl_if.slave  bus
);
    localparam int DW = $clog2(Depth);
    localparam logic [DW-1:0] CAP = DW'(Depth - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_PUSH = 2'd1,
        CMD_POP  = 2'd2
    } cmd_e;

    state_e        state_q;
    cmd_e          command_q;
    logic          enter_ack_q;
    logic          exit_ack_q;
    logic [DW-1:0] depth_q;
    logic          overflow_q;
    logic          underflow_q;
    logic          full;
    logic          empty;

    assign full  = (depth_q == CAP);
    assign empty = (depth_q == '0);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            command_q   <= CMD_NONE;
            enter_ack_q <= 1'b0;
            exit_ack_q  <= 1'b0;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            enter_ack_q <= 1'b0;
            exit_ack_q  <= 1'b0;

            // Clear first so a set later in this block overrides it.
            if (bus.i_err_clr) begin
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (!bus.i_stall) begin
                        if (bus.i_enter_req && !full) begin
                            state_q     <= ISSUE;
                            command_q   <= CMD_PUSH;
                            enter_ack_q <= 1'b1;
                        end else begin
                            // A blocked entry only wins priority when it can
                            // push; at full it flags overflow and lets a
                            // pending exit through, otherwise nothing could
                            // ever make room for it.
                            if (bus.i_enter_req) begin
                                overflow_q <= 1'b1;
                            end
                            // While an underflow ack is showing the requester
                            // has not yet dropped exit; do not consume it twice.
                            if (bus.i_exit_req && !exit_ack_q) begin
                                exit_ack_q <= 1'b1;
                                if (!empty) begin
                                    state_q   <= ISSUE;
                                    command_q <= CMD_POP;
                                end else begin
                                    underflow_q <= 1'b1;
                                end
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (command_q == CMD_PUSH) begin
                        depth_q <= depth_q + 1'b1;
                    end else if (command_q == CMD_POP) begin
                        depth_q <= depth_q - 1'b1;
                    end
                    command_q <= CMD_NONE;
                    state_q   <= SETTLE;
                end
                SETTLE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    command_q <= CMD_NONE;
                end
            endcase
        end
    end

    assign bus.o_command   = command_q;
    assign bus.o_enter_ack = enter_ack_q;
    assign bus.o_exit_ack  = exit_ack_q;
    assign bus.o_w_block   = (state_q != IDLE);
    assign bus.o_depth     = depth_q;
    assign bus.o_full      = full;
    assign bus.o_empty     = empty;
    assign bus.o_overflow  = overflow_q;
    assign bus.o_underflow = underflow_q;

endmodule

// File: tb/tb_regfile_stack_ctrl.sv
// tb_regfile_stack_ctrl
// Directed bench for regfile_stack_ctrl at Depth = 4 (CAP = 3), followed by a
// short random request stream checked against simple depth bookkeeping.
module tb_regfile_stack_ctrl;
    logic clk;
    logic rst_n;

    int unsigned errors;
    int unsigned checks;

    regfile_stack_ctrl_if #(.Depth(4)) bus ();

    regfile_stack_ctrl #(.Depth(4)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete push or pop starting from IDLE with no other request high.
    task automatic do_op(input bit push, input int unsigned exp_depth);
        if (push) bus.i_enter_req = 1'b1;
        else      bus.i_exit_req  = 1'b1;
        tick();
        check("op_cmd",        bus.o_command, push ? 1 : 2);
        check("op_enter_ack",  bus.o_enter_ack, push ? 1 : 0);
        check("op_exit_ack",   bus.o_exit_ack,  push ? 0 : 1);
        check("op_wblk_issue", bus.o_w_block, 1);
        bus.i_enter_req = 1'b0;
        bus.i_exit_req  = 1'b0;
        tick();
        check("op_depth",       bus.o_depth, exp_depth);
        check("op_cmd_settle",  bus.o_command, 0);
        check("op_ack_settle",  bus.o_enter_ack | bus.o_exit_ack, 0);
        check("op_wblk_settle", bus.o_w_block, 1);
        tick();
        check("op_wblk_idle",   bus.o_w_block, 0);
    endtask

    initial begin
        int unsigned exp_d;
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.i_enter_req = 1'b0;
        bus.i_exit_req  = 1'b0;
        bus.i_stall     = 1'b0;
        bus.i_err_clr   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_cmd",   bus.o_command, 0);
        check("rst_acks",  bus.o_enter_ack | bus.o_exit_ack, 0);
        check("rst_wblk",  bus.o_w_block, 0);
        check("rst_depth", bus.o_depth, 0);
        check("rst_empty", bus.o_empty, 1);
        check("rst_full",  bus.o_full, 0);
        check("rst_flags", bus.o_overflow | bus.o_underflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Push then pop
        do_op(1'b1, 1);
        do_op(1'b0, 0);
        check("pp_empty", bus.o_empty, 1);

        // Fill to CAP, then overflow with a pending entry
        do_op(1'b1, 1);
        do_op(1'b1, 2);
        do_op(1'b1, 3);
        check("fill_full", bus.o_full, 1);
        bus.i_enter_req = 1'b1;
        tick();
        check("ovf_cmd",  bus.o_command, 0);
        check("ovf_ack",  bus.o_enter_ack, 0);
        check("ovf_flag", bus.o_overflow, 1);
        check("ovf_wblk", bus.o_w_block, 0);
        tick();
        check("ovf_retry_cmd", bus.o_command, 0);
        bus.i_exit_req = 1'b1;
        tick();
        check("ovf_pop_cmd",   bus.o_command, 2);
        check("ovf_pop_xack",  bus.o_exit_ack, 1);
        check("ovf_pop_eack",  bus.o_enter_ack, 0);
        bus.i_exit_req = 1'b0;
        tick();
        check("ovf_pop_depth", bus.o_depth, 2);
        tick();
        tick();
        check("ovf_pend_cmd", bus.o_command, 1);
        check("ovf_pend_ack", bus.o_enter_ack, 1);
        bus.i_enter_req = 1'b0;
        tick();
        check("ovf_pend_depth", bus.o_depth, 3);
        tick();
        bus.i_err_clr = 1'b1;
        tick();
        check("ovf_clr", bus.o_overflow, 0);
        bus.i_err_clr = 1'b0;
        do_op(1'b0, 2);
        do_op(1'b0, 1);
        do_op(1'b0, 0);

        // Underflow, then a set coinciding with a clear, then clear
        bus.i_exit_req = 1'b1;
        tick();
        check("unf_cmd",  bus.o_command, 0);
        check("unf_ack",  bus.o_exit_ack, 1);
        check("unf_flag", bus.o_underflow, 1);
        check("unf_wblk", bus.o_w_block, 0);
        bus.i_exit_req = 1'b0;
        tick();
        check("unf_ack_pulse", bus.o_exit_ack, 0);
        check("unf_sticky",    bus.o_underflow, 1);
        check("unf_depth",     bus.o_depth, 0);
        bus.i_exit_req = 1'b1;
        bus.i_err_clr  = 1'b1;
        tick();
        check("unf_set_wins", bus.o_underflow, 1);
        bus.i_exit_req = 1'b0;
        tick();
        check("unf_cleared", bus.o_underflow, 0);
        bus.i_err_clr = 1'b0;

        // Simultaneous entry and exit at depth 1
        do_op(1'b1, 1);
        bus.i_enter_req = 1'b1;
        bus.i_exit_req  = 1'b1;
        tick();
        check("sim_push_cmd", bus.o_command, 1);
        check("sim_push_ack", bus.o_enter_ack, 1);
        check("sim_no_xack",  bus.o_exit_ack, 0);
        bus.i_enter_req = 1'b0;
        tick();
        check("sim_depth2", bus.o_depth, 2);
        check("sim_wblk_s", bus.o_w_block, 1);
        tick();
        check("sim_idle_cmd",  bus.o_command, 0);
        check("sim_idle_wblk", bus.o_w_block, 0);
        tick();
        check("sim_pop_cmd",  bus.o_command, 2);
        check("sim_pop_ack",  bus.o_exit_ack, 1);
        check("sim_pop_wblk", bus.o_w_block, 1);
        bus.i_exit_req = 1'b0;
        tick();
        check("sim_depth1", bus.o_depth, 1);
        tick();

        // Stall holds off acceptance
        bus.i_stall     = 1'b1;
        bus.i_enter_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_cmd",  bus.o_command, 0);
            check("stall_wblk", bus.o_w_block, 0);
        end
        bus.i_stall = 1'b0;
        tick();
        check("stall_rel_cmd", bus.o_command, 1);
        check("stall_rel_ack", bus.o_enter_ack, 1);
        bus.i_enter_req = 1'b0;
        tick();
        check("stall_depth", bus.o_depth, 2);
        tick();

        // Reset during ISSUE of a push at depth 2
        bus.i_enter_req = 1'b1;
        tick();
        check("rsti_cmd", bus.o_command, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rsti_depth", bus.o_depth, 0);
        check("rsti_cmd0",  bus.o_command, 0);
        check("rsti_ack",   bus.o_enter_ack, 0);
        check("rsti_wblk",  bus.o_w_block, 0);
        tick();
        check("rsti_hold_depth", bus.o_depth, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_first_cmd", bus.o_command, 1);
        check("rst_first_ack", bus.o_enter_ack, 1);
        bus.i_enter_req = 1'b0;
        tick();
        check("rst_first_depth", bus.o_depth, 1);
        tick();

        // Random stream: legal command, depth bounded and consistent with acks
        exp_d = bus.o_depth;
        for (int i = 0; i < 300; i++) begin
            bus.i_enter_req = ($urandom_range(0, 2) == 0);
            bus.i_exit_req  = ($urandom_range(0, 2) == 0);
            bus.i_stall     = ($urandom_range(0, 3) == 0);
            bus.i_err_clr   = ($urandom_range(0, 7) == 0);
            tick();
            check("rnd_cmd_legal", (bus.o_command != 2'd3), 1);
            check("rnd_depth",     bus.o_depth, exp_d);
            check("rnd_depth_rng", (bus.o_depth <= 2'd3), 1);
            check("rnd_eack",      bus.o_enter_ack, (bus.o_command == 2'd1));
            if (bus.o_command == 2'd1) exp_d = exp_d + 1;
            if (bus.o_command == 2'd2) exp_d = exp_d - 1;
        end
        bus.i_enter_req = 1'b0;
        bus.i_exit_req  = 1'b0;
        bus.i_stall     = 1'b0;
        bus.i_err_clr   = 1'b0;
        tick();
        check("rnd_final_depth", bus.o_depth, exp_d);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
